// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_if
//  Purpose  : Load/store unit that connects a single-cycle datapath to a
//             variable-latency data memory. It checks each access, latches it,
//             runs the request/ready handshake, holds the core with Stall, and
//             returns a lane-aligned, sign/zero-extended load result.
//  Ports    : clk, reset_n           - clock, async active-low reset
//             MemRead/MemWrite       - load / store strobes from the core
//             Funct3                 - RV32I width code
//             ALUResult, WriteData   - byte address, store data
//             ReadData, Stall,       - registered load result, core hold,
//             AccessErr                one-cycle error pulse
//             mem_req/we/addr/wdata/be, mem_ready, mem_rdata - memory side
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_if #(
    parameter int unsigned TIMEOUT = 255   // 1..255 REQ cycles before abort
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [2:0]  f3_q,    f3_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q,    we_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [31:0] rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Request decode (from the live core inputs, used only in IDLE)
    // ------------------------------------------------------------------
    logic        f3_ok;
    logic        aligned;
    logic        legal_req;
    logic        illegal_req;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;

    always_comb begin
        f3_ok = 1'b0;
        if (MemRead) begin
            case (Funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
                default:                                f3_ok = 1'b0;
            endcase
        end else if (MemWrite) begin
            case (Funct3)
                3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
                default:                f3_ok = 1'b0;
            endcase
        end
    end

    // Funct3[1:0] carries the width for both loads and stores.
    always_comb begin
        case (Funct3[1:0])
            2'b01:   aligned = ~ALUResult[0];
            2'b10:   aligned = (ALUResult[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign legal_req   = (MemRead ^ MemWrite) & f3_ok & aligned;
    assign illegal_req = (MemRead | MemWrite) & ~legal_req;

    // Store lane placement; loads always fetch the full word.
    always_comb begin
        in_be    = 4'b1111;
        in_wdata = WriteData;
        if (MemWrite) begin
            case (Funct3[1:0])
                2'b00: begin
                    in_be    = 4'b0001 << ALUResult[1:0];
                    in_wdata = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    in_be    = 4'b0011 << ALUResult[1:0];
                    in_wdata = {2{WriteData[15:0]}};
                end
                default: begin
                    in_be    = 4'b1111;
                    in_wdata = WriteData;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the returned word, using the latched access
    // ------------------------------------------------------------------
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] ld_ext;

    assign byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sh = mem_rdata >> {addr_q[1], 4'b0000};

    // Funct3[2] set means the unsigned variant (LBU/LHU).
    always_comb begin
        case (f3_q[1:0])
            2'b00:   ld_ext = {{24{byte_sh[7]  & ~f3_q[2]}}, byte_sh[7:0]};
            2'b01:   ld_ext = {{16{half_sh[15] & ~f3_q[2]}}, half_sh[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    logic [7:0] cnt_inc;
    logic       stall_c;
    logic       err_c;
    logic       req_c;

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        stall_c = 1'b0;
        err_c   = 1'b0;
        req_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (legal_req) begin
                    addr_d  = ALUResult;
                    f3_d    = Funct3;
                    be_d    = in_be;
                    wdata_d = in_wdata;
                    we_d    = MemWrite;
                    stall_c = 1'b1;
                    state_d = ST_REQ;
                end else if (illegal_req) begin
                    err_c = 1'b1;
                end
            end
            ST_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                cnt_d   = cnt_inc;
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = ld_ext;
                    end
                    cnt_d   = 8'd0;
                    state_d = ST_DONE;
                // cnt_inc is the number of REQ cycles including this one, so
                // the request is visible for exactly TIMEOUT cycles.
                end else if (cnt_inc == TIMEOUT_C) begin
                    err_c   = 1'b1;
                    rdata_d = 32'd0;
                    cnt_d   = 8'd0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Core commits this cycle; its inputs still describe the
                // finished instruction, so they must not start a new access.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall/AccessErr depend on live inputs in IDLE; gating with reset_n
    // keeps every output low while reset is held.
    assign Stall     = stall_c & reset_n;
    assign AccessErr = err_c & reset_n;
    assign ReadData  = rdata_q;
    assign mem_req   = req_c;
    assign mem_we    = req_c & we_q;
    assign mem_addr  = req_c ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata = req_c ? wdata_q : 32'd0;
    assign mem_be    = req_c ? be_q : 4'd0;

endmodule
`default_nettype wire
